instr_fetch: RTL and testbench

Instruction fetch stage directly upstream of the opcode decoder in the 8-bit CPU datapath. Owns the program counter, reads opcode bytes (plus one operand byte for two-byte instructions) from program memory over a ready-handshake, and presents the latched opcode on ir_out to the decoder's ir_in. Waits for the execution controller to report completion, then applies any taken branch and fetches the next instruction.

---
 rtl/instr_fetch.sv | 120 ++++++++++++
 tb/tb_instr_fetch.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns pc, reads opcode/operand bytes, hands them to the decoder.
// Optional INSTR_COUNT_EN adds a 16-bit count of issued instructions.
module instr_fetch #(
    parameter int          ADDR_W  = 8,
    parameter logic [7:0]  HALT_OP = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    output logic [7:0]        ir_out,
    output logic [7:0]        operand,
    output logic              ir_valid,
    input  logic              exec_done,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
`ifdef INSTR_COUNT_EN
    ,
    output logic [15:0]       instr_count
`endif
);

    typedef enum logic [2:0] {
        RST,
        F_OP,
        F_ARG,
        ISSUE,
        EXEC,
        HALT
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [7:0]        operand_q, operand_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST;
            pc_q      <= '0;
            ir_q      <= 8'h00;
            operand_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            operand_q <= operand_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        operand_d = operand_q;
        unique case (state_q)
            RST: state_d = F_OP;
            F_OP: begin
                if (mem_ready) begin
                    ir_d = mem_rdata;
                    pc_d = pc_q + ADDR_W'(1);
                    // the halt opcode never takes an operand byte
                    if (mem_rdata != HALT_OP && mem_rdata[7:5] == 3'b111)
                        state_d = F_ARG;
                    else
                        state_d = ISSUE;
                end
            end
            F_ARG: begin
                if (mem_ready) begin
                    operand_d = mem_rdata;
                    pc_d      = pc_q + ADDR_W'(1);
                    state_d   = ISSUE;
                end
            end
            ISSUE: state_d = (ir_q == HALT_OP) ? HALT : EXEC;
            EXEC: begin
                if (exec_done) begin
                    if (branch_taken)
                        pc_d = branch_target;
                    state_d = F_OP;
                end
            end
            HALT: state_d = HALT;
            default: state_d = RST;
        endcase
    end

    assign mem_addr = pc_q;
    assign mem_rd   = (state_q == F_OP) || (state_q == F_ARG);
    assign ir_out   = ir_q;
    assign operand  = operand_q;
    assign ir_valid = (state_q == ISSUE);
    assign pc       = pc_q;
    assign halted   = (state_q == HALT);

`ifdef INSTR_COUNT_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (state_q == ISSUE)
            count_d = count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= 16'd0;
        else
            count_q <= count_d;
    end

    assign instr_count = count_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: byte-wide memory model, hand-computed expectations.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_rdata;
    logic       mem_ready;
    logic [7:0] ir_out;
    logic [7:0] operand;
    logic       ir_valid;
    logic       exec_done;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic [7:0] pc;
    logic       halted;
`ifdef INSTR_COUNT_EN
    logic [15:0] instr_count;
`endif

    logic [7:0] mem [256];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    instr_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .ir_out        (ir_out),
        .operand       (operand),
        .ir_valid      (ir_valid),
        .exec_done     (exec_done),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .halted        (halted)
`ifdef INSTR_COUNT_EN
        ,
        .instr_count   (instr_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h0B;
        mem[8'h01] = 8'hE5;
        mem[8'h02] = 8'h3C;
        mem[8'h40] = 8'h01;
        mem[8'hFF] = 8'hE0;
        mem[8'h10] = 8'hFF;
        rst_n         = 1'b0;
        mem_ready     = 1'b1;
        exec_done     = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 8'h00;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_pc", pc, 0);
        check("rst_ir", ir_out, 0);
        check("rst_operand", operand, 0);
        check("rst_ir_valid", ir_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_mem_rd", mem_rd, 0);
        rst_n = 1'b1;

        // single-byte opcode 0x0B at 0
        tick();
        check("fop_mem_rd", mem_rd, 1);
        check("fop_addr", mem_addr, 0);
        tick();
        check("sb_valid", ir_valid, 1);
        check("sb_ir", ir_out, 8'h0B);
        check("sb_pc", pc, 1);
        exec_done = 1'b1;
        tick();
        check("sb_valid_pulse", ir_valid, 0);
        check("exec_mem_rd", mem_rd, 0);
        tick();
        exec_done = 1'b0;
        check("sb_next_rd", mem_rd, 1);
        check("sb_next_addr", mem_addr, 1);

        // two-byte opcode 0xE5, operand 0x3C
        tick();
        check("tb_arg_addr", mem_addr, 2);
        check("tb_arg_rd", mem_rd, 1);
        check("tb_arg_novalid", ir_valid, 0);
        tick();
        check("tb_valid", ir_valid, 1);
        check("tb_ir", ir_out, 8'hE5);
        check("tb_operand", operand, 8'h3C);
        check("tb_pc", pc, 3);

        // branch_taken without exec_done is ignored
        branch_taken  = 1'b1;
        branch_target = 8'h40;
        tick();
        check("br_noexec_pc", pc, 3);
        check("br_noexec_valid", ir_valid, 0);
        tick();
        check("br_wait_pc", pc, 3);
        check("br_wait_rd", mem_rd, 0);
        exec_done = 1'b1;
        tick();
        exec_done    = 1'b0;
        branch_taken = 1'b0;
        check("br_addr", mem_addr, 8'h40);
        check("br_rd", mem_rd, 1);

        // memory stall for three cycles
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_rd", mem_rd, 1);
            check("stall_addr", mem_addr, 8'h40);
            check("stall_valid", ir_valid, 0);
        end
        mem_ready = 1'b1;
        tick();
        check("stall_done_valid", ir_valid, 1);
        check("stall_done_ir", ir_out, 8'h01);
        check("stall_done_pc", pc, 8'h41);
        check("sb_keeps_operand", operand, 8'h3C);

        // branch to FF, then wrap between opcode and operand
        exec_done     = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 8'hFF;
        tick();
        tick();
        exec_done    = 1'b0;
        branch_taken = 1'b0;
        check("wrap_addr", mem_addr, 8'hFF);
        mem[8'h00] = 8'h77;
        tick();
        check("wrap_arg_addr", mem_addr, 8'h00);
        check("wrap_arg_rd", mem_rd, 1);
        tick();
        check("wrap_valid", ir_valid, 1);
        check("wrap_ir", ir_out, 8'hE0);
        check("wrap_operand", operand, 8'h77);
        check("wrap_pc", pc, 8'h01);

        // halt opcode at 0x10
        exec_done     = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 8'h10;
        tick();
        tick();
        exec_done    = 1'b0;
        branch_taken = 1'b0;
        check("halt_fetch_addr", mem_addr, 8'h10);
        tick();
        check("halt_valid", ir_valid, 1);
        check("halt_ir", ir_out, 8'hFF);
        check("halt_pc", pc, 8'h11);
        check("halt_no_arg_rd", mem_rd, 0);
        tick();
        check("halted", halted, 1);
`ifdef INSTR_COUNT_EN
        check("count", instr_count, 5);
`endif
        exec_done = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("halt_rd", mem_rd, 0);
            check("halt_novalid", ir_valid, 0);
            check("halt_hold", halted, 1);
        end
        exec_done = 1'b0;
        check("halt_pc_frozen", pc, 8'h11);

        // async reset mid-EXEC after a two-byte instruction
        rst_n = 1'b0;
        #1;
        check("arst_halted", halted, 0);
        check("arst_pc", pc, 0);
        mem[8'h00] = 8'hE9;
        mem[8'h01] = 8'h5A;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check("pre_rst_valid", ir_valid, 1);
        check("pre_rst_operand", operand, 8'h5A);
        tick();
        check("pre_rst_exec_rd", mem_rd, 0);
        check("pre_rst_pc", pc, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_pc", pc, 0);
        check("mid_rst_ir", ir_out, 0);
        check("mid_rst_operand", operand, 0);
        check("mid_rst_valid", ir_valid, 0);
        check("mid_rst_halted", halted, 0);
        check("mid_rst_rd", mem_rd, 0);
`ifdef INSTR_COUNT_EN
        check("mid_rst_count", instr_count, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
